auto_exposure_controller: RTL and testbench
===========================================

Name: auto_exposure_controller

Overview:
- Closed-loop exposure stage, directly upstream of camera_configurator.
- Measures mean luma of each camera frame from the pixel stream and steps the 8-bit exposure value toward a target.
- Issues single-cycle update requests; the configurator consumes them on its exposure / ready_update_in inputs.
- Runs entirely in the camera clock domain.

Parameters:
ACC_W, 24, width of the per-frame luma sum and of the pixel counter; both saturate.
EXP_INIT, 8'd128, exposure value after reset.
EXP_MIN, 8'd1, lower clamp for exposure.
EXP_MAX, 8'd255, upper clamp for exposure.
STEP, 8'd4, exposure increment/decrement per decision.
DEADBAND, 8'd8, half-width of the no-change band around the target.
SETTLE_FRAMES, 2, complete frames ignored after each issued update.

Ports:
clk_camera  input  1  camera clock; only clock.
sys_rst_camera_n  input  1  asynchronous active-low reset.
enable_in  input  1  level; loop runs while high.
config_done_in  input  1  level; camera initial configuration finished.
bus_active_in  input  1  configurator I2C bus busy.
target_in  input  8  desired mean luma; sampled at each decision.
frame_start_in  input  1  one-cycle strobe, first cycle of a frame.
frame_end_in  input  1  one-cycle strobe, last cycle of a frame.
pixel_valid_in  input  1  luma sample valid.
pixel_luma_in  input  8  luma sample.
exposure_out  output  8  current exposure; drives configurator exposure.
ready_update_out  output  1  one-cycle update request; drives ready_update_in.
at_limit_out  output  1  exposure_out equals EXP_MIN or EXP_MAX.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state IDLE
  - exposure_out = EXP_INIT
  - ready_update_out = 0
  - at_limit_out = (EXP_INIT == EXP_MIN or EXP_MAX)
  - sum, count and settle counter = 0
- States:
  - IDLE: wait for enable_in && config_done_in, then go to WAIT_SOF.
  - WAIT_SOF: wait for frame_start_in, then go to MEASURE.
  - MEASURE: accumulate until frame_end_in, then go to MUL.
  - MUL: one cycle, then CMP.
  - CMP: go to ISSUE on a change, otherwise WAIT_SOF.
  - ISSUE: wait for bus idle, pulse, then go to SETTLE.
  - SETTLE: go to WAIT_SOF after SETTLE_FRAMES frame_end_in strobes.
- Accumulation:
  - The frame_start_in cycle clears sum and count and also accumulates that cycle's pixel if pixel_valid_in is high.
  - A pixel in the frame_end_in cycle is included.
  - sum and count saturate at all-ones; they never wrap.
  - frame_start_in seen in MEASURE restarts the frame (resync).
  - frame_end_in seen outside MEASURE or SETTLE is ignored.
- MUL:
  - lo_t = max(target_in - DEADBAND, 0) and hi_t = min(target_in + DEADBAND, 255), both computed in 9 bits.
  - Register lo = lo_t*count and hi = hi_t*count, each ACC_W+8 bits.
- CMP:
  - count == 0: no change.
  - sum < lo: new = min(exposure + STEP, EXP_MAX).
  - sum > hi: new = max(exposure - STEP, EXP_MIN).
  - Otherwise: no change.
  - Compute in 9 bits before clamping.
  - If new != exposure_out, register it into exposure_out and go to ISSUE; else go to WAIT_SOF.
- ISSUE:
  - ready_update_out is high for exactly one cycle: the first ISSUE cycle with bus_active_in low.
  - This is earliest 3 cycles after the frame_end_in cycle.
  - exposure_out is already at its new value on that cycle and stays unchanged until the next CMP, at least SETTLE_FRAMES frames later.
  - That satisfies the configurator's two-cycle write window.
  - bus_active_in high defers the pulse with no timeout.
- SETTLE: counts frame_end_in strobes; pixels in these frames are not used.
- enable_in or config_done_in low:
  - From WAIT_SOF, MEASURE, MUL, CMP or SETTLE, go to IDLE next cycle; exposure_out is retained.
  - ISSUE always completes its pulse first.
- Async reset mid-ISSUE cancels the pulse; exposure_out returns to EXP_INIT and no request is emitted.
- at_limit_out is registered and tracks exposure_out.

Decomposition:
- Package ae_pkg holds:
  - ae_state_t enum: IDLE, WAIT_SOF, MEASURE, MUL, CMP, ISSUE, SETTLE.
  - Default exposure constants: EXP_INIT/MIN/MAX, STEP, DEADBAND.
  - Shared ACC_W default.
- Sub-module luma_accumulator owns the saturating sum/count and the start/end resync.
  - Outputs: sum, count, and a frame_done strobe.
  - The top level keeps the FSM, the threshold multiply and the clamp.

Test Plan:
- Dark frame: EXP_INIT 128, target 110, 64 pixels of luma 50 -> exposure_out 132; one ready_update_out pulse 3 cycles after frame_end_in.
- On-target frame: 64 pixels of luma 110 (and 118) -> no pulse, exposure stays 128. Bright frame: luma 200 -> 124.
- Clamp: exposure 253, dark frame -> 255 and at_limit_out 1. Next dark frame -> no pulse.
- Bus busy: bus_active_in high for 20 cycles across ISSUE -> pulse on the first idle cycle; exposure_out stable throughout.
- Settle: after an update, two dark frames -> no decision; the third dark frame -> +4.
- Corner cases, each checked separately:
  - Empty frame (count 0) -> no update.
  - All pixels 255 with ACC_W=8 -> sum saturates at 255, no wrap.
  - Reset asserted in ISSUE -> ready_update_out 0, exposure_out 128.

Source files
------------

// File: rtl/ae_pkg.sv
// Shared types and default constants for the auto-exposure loop.
package ae_pkg;

    localparam int unsigned ACC_W_DEF    = 24;
    localparam logic [7:0]  EXP_INIT_DEF = 8'd128;
    localparam logic [7:0]  EXP_MIN_DEF  = 8'd1;
    localparam logic [7:0]  EXP_MAX_DEF  = 8'd255;
    localparam logic [7:0]  STEP_DEF     = 8'd4;
    localparam logic [7:0]  DEADBAND_DEF = 8'd8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSof,
        StMeasure,
        StMul,
        StCmp,
        StIssue,
        StSettle
    } ae_state_t;

endpackage

// File: rtl/luma_accumulator.sv
// Per-frame saturating luma sum and pixel count with start-of-frame resync.
module luma_accumulator
    import ae_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk_camera,
    input  logic             rst_n,
    input  logic             sof_en_i,
    input  logic             acc_en_i,
    input  logic             frame_start_i,
    input  logic             frame_end_i,
    input  logic             pixel_valid_i,
    input  logic [7:0]       pixel_luma_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] count_o,
    output logic             frame_done_o
);

    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] pix_ext;
    logic [ACC_W:0]   sum_add;
    logic [ACC_W:0]   cnt_add;

    assign pix_ext = ACC_W'(pixel_luma_i);
    assign sum_add = {1'b0, sum_q} + {1'b0, pix_ext};
    assign cnt_add = {1'b0, count_q} + (ACC_W + 1)'(1);

    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        // A start strobe restarts the frame and still counts its own pixel.
        if (sof_en_i && frame_start_i) begin
            sum_d   = pixel_valid_i ? pix_ext : '0;
            count_d = pixel_valid_i ? ACC_W'(1) : '0;
        end else if (acc_en_i && pixel_valid_i) begin
            sum_d   = sum_add[ACC_W] ? '1 : sum_add[ACC_W-1:0];
            count_d = cnt_add[ACC_W] ? '1 : cnt_add[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_camera or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign sum_o        = sum_q;
    assign count_o      = count_q;
    assign frame_done_o = acc_en_i && frame_end_i;

endmodule

// File: rtl/auto_exposure_controller.sv
// Closed-loop exposure: measures mean frame luma and steps exposure toward a target,
// issuing one-cycle update requests to the camera configurator.
module auto_exposure_controller
    import ae_pkg::*;
#(
    parameter int unsigned ACC_W         = ACC_W_DEF,
    parameter logic [7:0]  EXP_INIT      = EXP_INIT_DEF,
    parameter logic [7:0]  EXP_MIN       = EXP_MIN_DEF,
    parameter logic [7:0]  EXP_MAX       = EXP_MAX_DEF,
    parameter logic [7:0]  STEP          = STEP_DEF,
    parameter logic [7:0]  DEADBAND      = DEADBAND_DEF,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic       clk_camera,
    input  logic       sys_rst_camera_n,
    input  logic       enable_in,
    input  logic       config_done_in,
    input  logic       bus_active_in,
    input  logic [7:0] target_in,
    input  logic       frame_start_in,
    input  logic       frame_end_in,
    input  logic       pixel_valid_in,
    input  logic [7:0] pixel_luma_in,
    output logic [7:0] exposure_out,
    output logic       ready_update_out,
    output logic       at_limit_out
);

    localparam logic AT_LIMIT_INIT = (EXP_INIT == EXP_MIN) || (EXP_INIT == EXP_MAX);

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    ae_state_t          state_q;
    logic [7:0]         exposure_q;
    logic               at_limit_q;
    logic [ACC_W+7:0]   lo_q;
    logic [ACC_W+7:0]   hi_q;
    logic [7:0]         settle_q;
    logic               run;
    logic               sof_en;
    logic               acc_en;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   count;
    logic               frame_done;
    logic [8:0]         tgt9;
    logic [8:0]         db9;
    logic [8:0]         lo_t;
    logic [8:0]         hi_t;
    logic [8:0]         exp9;
    logic [8:0]         up9;
    logic [7:0]         inc_val;
    logic [7:0]         dec_val;
    logic [7:0]         new_exp;
    logic [ACC_W+7:0]   sum_ext;

    // Reset asserts asynchronously, releases two clocks after the pin deasserts.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign run    = enable_in && config_done_in;
    assign sof_en = run && ((state_q == StWaitSof) || (state_q == StMeasure));
    assign acc_en = run && (state_q == StMeasure);

    luma_accumulator #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk_camera   (clk_camera),
        .rst_n        (rst_n),
        .sof_en_i     (sof_en),
        .acc_en_i     (acc_en),
        .frame_start_i(frame_start_in),
        .frame_end_i  (frame_end_in),
        .pixel_valid_i(pixel_valid_in),
        .pixel_luma_i (pixel_luma_in),
        .sum_o        (sum),
        .count_o      (count),
        .frame_done_o (frame_done)
    );

    always_comb begin
        tgt9 = {1'b0, target_in};
        db9  = {1'b0, DEADBAND};
        lo_t = (tgt9 < db9) ? 9'd0 : tgt9 - db9;
        hi_t = ((tgt9 + db9) > 9'd255) ? 9'd255 : tgt9 + db9;
    end

    always_comb begin
        exp9    = {1'b0, exposure_q};
        up9     = exp9 + {1'b0, STEP};
        inc_val = (up9 > {1'b0, EXP_MAX}) ? EXP_MAX : up9[7:0];
        dec_val = (exp9 < ({1'b0, STEP} + {1'b0, EXP_MIN})) ? EXP_MIN : exposure_q - STEP;
        sum_ext = (ACC_W + 8)'(sum);
        new_exp = exposure_q;
        if (count != '0) begin
            if (sum_ext < lo_q) begin
                new_exp = inc_val;
            end else if (sum_ext > hi_q) begin
                new_exp = dec_val;
            end
        end
    end

    always_ff @(posedge clk_camera or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            exposure_q <= EXP_INIT;
            at_limit_q <= AT_LIMIT_INIT;
            lo_q       <= '0;
            hi_q       <= '0;
            settle_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run) state_q <= StWaitSof;
                end
                StWaitSof: begin
                    if (!run) state_q <= StIdle;
                    else if (frame_start_in) state_q <= StMeasure;
                end
                StMeasure: begin
                    if (!run) state_q <= StIdle;
                    else if (frame_done) state_q <= StMul;
                end
                StMul: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end else begin
                        lo_q    <= (ACC_W + 8)'(lo_t) * (ACC_W + 8)'(count);
                        hi_q    <= (ACC_W + 8)'(hi_t) * (ACC_W + 8)'(count);
                        state_q <= StCmp;
                    end
                end
                StCmp: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end else if (new_exp != exposure_q) begin
                        exposure_q <= new_exp;
                        at_limit_q <= (new_exp == EXP_MIN) || (new_exp == EXP_MAX);
                        state_q    <= StIssue;
                    end else begin
                        state_q <= StWaitSof;
                    end
                end
                // Completes its pulse even if the loop is disabled meanwhile.
                StIssue: begin
                    if (!bus_active_in) begin
                        settle_q <= '0;
                        state_q  <= (SETTLE_FRAMES == 0) ? StWaitSof : StSettle;
                    end
                end
                StSettle: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end else if (frame_end_in) begin
                        if ((32'(settle_q) + 32'd1) >= SETTLE_FRAMES) state_q <= StWaitSof;
                        else settle_q <= settle_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The request must coincide with the first idle-bus ISSUE cycle, so it is decoded.
    assign ready_update_out = (state_q == StIssue) && !bus_active_in;
    assign exposure_out     = exposure_q;
    assign at_limit_out     = at_limit_q;

endmodule

// File: tb/tb_auto_exposure_controller.sv
// Randomized scoreboard bench for auto_exposure_controller (two configurations).
module tb_auto_exposure_controller;

    typedef struct {
        logic [7:0] exp;
        logic       lim;
        int         lat;
    } exp_t;

    logic       clk;
    logic [1:0] rst_n, en, cfg, bus, fs, fe, pv, rdy, lim;
    logic [7:0] target [2];
    logic [7:0] luma   [2];
    logic [7:0] exp_o  [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_fe  [2];
    int   m_exp    [2];
    int   m_skip   [2];
    exp_t sbq0 [$];
    exp_t sbq1 [$];

    auto_exposure_controller u_dut0 (
        .clk_camera      (clk),
        .sys_rst_camera_n(rst_n[0]),
        .enable_in       (en[0]),
        .config_done_in  (cfg[0]),
        .bus_active_in   (bus[0]),
        .target_in       (target[0]),
        .frame_start_in  (fs[0]),
        .frame_end_in    (fe[0]),
        .pixel_valid_in  (pv[0]),
        .pixel_luma_in   (luma[0]),
        .exposure_out    (exp_o[0]),
        .ready_update_out(rdy[0]),
        .at_limit_out    (lim[0])
    );

    auto_exposure_controller #(
        .ACC_W   (8),
        .EXP_INIT(8'd253)
    ) u_dut1 (
        .clk_camera      (clk),
        .sys_rst_camera_n(rst_n[1]),
        .enable_in       (en[1]),
        .config_done_in  (cfg[1]),
        .bus_active_in   (bus[1]),
        .target_in       (target[1]),
        .frame_start_in  (fs[1]),
        .frame_end_in    (fe[1]),
        .pixel_valid_in  (pv[1]),
        .pixel_luma_in   (luma[1]),
        .exposure_out    (exp_o[1]),
        .ready_update_out(rdy[1]),
        .at_limit_out    (lim[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every request pulse must match the oldest scoreboard entry.
    task automatic check_pulse(input int d);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
        if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
        if (!have) begin
            check($sformatf("dut%0d_unexpected_pulse", d), 32'd1, 32'd0);
        end else begin
            check($sformatf("dut%0d_pulse_exposure", d), 32'(exp_o[d]), 32'(e.exp));
            check($sformatf("dut%0d_pulse_at_limit", d), 32'(lim[d]), 32'(e.lim));
            check($sformatf("dut%0d_pulse_latency", d), 32'(cyc - last_fe[d]), 32'(e.lat));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fe[d] === 1'b1) last_fe[d] = cyc;
            if (rdy[d] === 1'b1) check_pulse(d);
        end
    end

    // Reference model: one decision per measured frame from mean-luma rules.
    task automatic model_frame(input int d, input longint sum, input longint cnt,
                               input int tgt, input int lat);
        longint accmax, s, c, lo_t, hi_t;
        int     nw;
        exp_t   e;
        if (m_skip[d] > 0) begin
            m_skip[d]--;
            return;
        end
        accmax = (d == 0) ? 64'd16777215 : 64'd255;
        s      = (sum > accmax) ? accmax : sum;
        c      = (cnt > accmax) ? accmax : cnt;
        lo_t   = (tgt < 8) ? 0 : tgt - 8;
        hi_t   = (tgt + 8 > 255) ? 255 : tgt + 8;
        nw     = m_exp[d];
        if (c > 0 && s < lo_t * c)      nw = (m_exp[d] + 4 > 255) ? 255 : m_exp[d] + 4;
        else if (c > 0 && s > hi_t * c) nw = (m_exp[d] - 4 < 1) ? 1 : m_exp[d] - 4;
        if (nw != m_exp[d]) begin
            e.exp = 8'(nw);
            e.lim = (nw == 1) || (nw == 255);
            e.lat = lat;
            if (d == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
            m_exp[d]  = nw;
            m_skip[d] = 2;
        end
    endtask

    // mode: 0 no valid pixels, 1 all valid, 2 random holes.
    task automatic send_frame(input int d, input int n, input int lmin, input int lmax,
                              input int mode, input int tgt, input int busy);
        longint sum = 0;
        longint cnt = 0;
        target[d] = 8'(tgt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            fs[d]   = (i == 0);
            fe[d]   = (i == n - 1);
            pv[d]   = (mode == 1) || (mode == 2 && $urandom_range(0, 3) != 0);
            luma[d] = 8'($urandom_range(lmin, lmax));
            if (pv[d]) begin
                sum += luma[d];
                cnt++;
            end
            if (i == n - 1 && busy > 0) bus[d] = 1'b1;
        end
        @(posedge clk); #1;
        fs[d] = 1'b0;
        fe[d] = 1'b0;
        pv[d] = 1'b0;
        model_frame(d, sum, cnt, tgt, (busy > 0) ? busy : 3);
        if (busy > 0) begin
            for (int k = 2; k < busy; k++) begin
                @(posedge clk); #1;
                if (k >= 3) begin
                    check("busy_no_pulse", 32'(rdy[d]), 32'd0);
                    check("busy_exposure_stable", 32'(exp_o[d]), 32'(m_exp[d]));
                end
            end
            @(posedge clk); #1;
            bus[d] = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
        check($sformatf("dut%0d_exposure_after_frame", d), 32'(exp_o[d]), 32'(m_exp[d]));
        check($sformatf("dut%0d_at_limit_after_frame", d), 32'(lim[d]),
              32'((m_exp[d] == 1) || (m_exp[d] == 255)));
    endtask

    task automatic drain_settle(input int d);
        while (m_skip[d] > 0) send_frame(d, 16, 100, 120, 1, 110, 0);
    endtask

    initial begin
        rst_n = 2'b00; en = 2'b11; cfg = 2'b11; bus = 2'b00;
        fs = 2'b00; fe = 2'b00; pv = 2'b00;
        for (int d = 0; d < 2; d++) begin
            target[d] = 8'd110; luma[d] = 8'd0; last_fe[d] = 0; m_skip[d] = 0;
        end
        m_exp[0] = 128;
        m_exp[1] = 253;
        repeat (3) @(posedge clk);
        #1;
        check("reset_exposure0", 32'(exp_o[0]), 32'd128);
        check("reset_ready0", 32'(rdy[0]), 32'd0);
        check("reset_at_limit0", 32'(lim[0]), 32'd0);
        check("reset_exposure1", 32'(exp_o[1]), 32'd253);
        check("reset_at_limit1", 32'(lim[1]), 32'd0);
        rst_n = 2'b11;
        repeat (5) @(posedge clk);

        // Directed: dark, settle, on-target, bright.
        send_frame(0, 64, 50, 50, 1, 110, 0);
        send_frame(0, 64, 50, 50, 1, 110, 0);
        send_frame(0, 64, 50, 50, 1, 110, 0);
        send_frame(0, 64, 50, 50, 1, 110, 0);
        drain_settle(0);
        send_frame(0, 64, 110, 110, 1, 110, 0);
        send_frame(0, 64, 118, 118, 1, 110, 0);
        send_frame(0, 64, 200, 200, 1, 110, 0);
        drain_settle(0);

        // Empty frame, then bus held busy across ISSUE.
        send_frame(0, 8, 0, 255, 0, 200, 0);
        send_frame(0, 64, 50, 50, 1, 110, 20);
        drain_settle(0);

        // Randomized frames.
        for (int r = 0; r < 24; r++) begin
            int lo = $urandom_range(0, 255);
            int hi = $urandom_range(lo, (lo + 60 > 255) ? 255 : lo + 60);
            send_frame(0, $urandom_range(2, 80), lo, hi, $urandom_range(1, 2),
                       $urandom_range(0, 255), 0);
        end

        // Narrow accumulator: clamp at max, then saturation (wrapped sum would be 240).
        send_frame(1, 64, 50, 50, 1, 110, 0);
        drain_settle(1);
        send_frame(1, 64, 50, 50, 1, 110, 0);
        send_frame(1, 16, 255, 255, 1, 7, 0);

        // Reset while ISSUE is stalled by a busy bus.
        drain_settle(0);
        bus[0] = 1'b1;
        if (m_exp[0] < 255) send_frame(0, 32, 20, 20, 1, 200, 0);
        else                send_frame(0, 32, 250, 250, 1, 10, 0);
        check("stall_no_pulse", 32'(rdy[0]), 32'd0);
        rst_n[0] = 1'b0;
        #1;
        check("reset_in_issue_ready", 32'(rdy[0]), 32'd0);
        check("reset_in_issue_exposure", 32'(exp_o[0]), 32'd128);
        sbq0.delete();
        m_exp[0]  = 128;
        m_skip[0] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_ready", 32'(rdy[0]), 32'd0);
        bus[0]   = 1'b0;
        rst_n[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_exposure", 32'(exp_o[0]), 32'd128);

        check("sb0_drained", 32'(sbq0.size()), 32'd0);
        check("sb1_drained", 32'(sbq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
